// File: rtl/mcp3_arb32_rr_pkg.sv
// Shared constants and state encoding for the 32-way round-robin arbiter.
package mcp3_arb32_rr_pkg;

    localparam int unsigned MCP3_ARB_NUM_REQ = 32;
    localparam int unsigned MCP3_ARB_ID_W    = 5;
    localparam int unsigned MCP3_ARB_WD_W    = 8;

    typedef enum logic {
        MCP3_ARB_IDLE  = 1'b0,
        MCP3_ARB_OWNED = 1'b1
    } mcp3_arb_state_e;

endpackage

// File: rtl/mcp3_decoder5x032.sv
// 5-to-32 binary-to-one-hot decoder.
module mcp3_decoder5x032 (
    input  logic [4:0]  din,
    output logic [31:0] dout
);

    assign dout = 32'(1) << din;

endmodule

// File: rtl/mcp3_rr_pick32.sv
// Combinational round-robin search: first set req bit at or above ptr, with wrap.
module mcp3_rr_pick32
    import mcp3_arb32_rr_pkg::*;
(
    input  logic [MCP3_ARB_NUM_REQ-1:0] req,
    input  logic [MCP3_ARB_ID_W-1:0]    ptr,
    output logic                        any,
    output logic [MCP3_ARB_ID_W-1:0]    winner
);

    logic [MCP3_ARB_NUM_REQ-1:0] rot;
    logic [MCP3_ARB_ID_W-1:0]    idx;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        rot = 32'({req, req} >> ptr);
        idx = '0;
        for (int i = MCP3_ARB_NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = 5'(i);
            end
        end
    end

    assign any    = |req;
    assign winner = idx + ptr;

endmodule

// File: rtl/mcp3_arb32_rr.sv
// 32-requester round-robin arbiter with hold-until-release grants.
// Optional grant watchdog enabled by defining MCP3_ARB32_WATCHDOG_EN.
module mcp3_arb32_rr
    import mcp3_arb32_rr_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [MCP3_ARB_NUM_REQ-1:0] req,
    input  logic                        release_pulse,
    output logic                        gnt_valid,
    output logic [MCP3_ARB_ID_W-1:0]    gnt_id,
    output logic [MCP3_ARB_NUM_REQ-1:0] gnt_onehot,
    output logic                        timeout_err
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("mcp3_arb32_rr: TIMEOUT_CYC must be within 1..255");
    end

    mcp3_arb_state_e             state_q, state_d;
    logic [MCP3_ARB_ID_W-1:0]    ptr_q, ptr_d;
    logic                        gnt_valid_q, gnt_valid_d;
    logic [MCP3_ARB_ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic                        end_grant;
    logic                        pick_any;
    logic [MCP3_ARB_ID_W-1:0]    pick_winner;
    logic [MCP3_ARB_NUM_REQ-1:0] dec_onehot;
`ifdef MCP3_ARB32_WATCHDOG_EN
    logic [MCP3_ARB_WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic                        timeout_err_q, timeout_err_d;
`endif

    mcp3_rr_pick32 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    mcp3_decoder5x032 u_dec (
        .din  (gnt_id_q),
        .dout (dec_onehot)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        end_grant   = release_pulse;
`ifdef MCP3_ARB32_WATCHDOG_EN
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = 1'b0;
`endif
        unique case (state_q)
            MCP3_ARB_IDLE: begin
                if (pick_any) begin
                    state_d     = MCP3_ARB_OWNED;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = pick_winner;
`ifdef MCP3_ARB32_WATCHDOG_EN
                    wd_cnt_d    = '0;
`endif
                end
            end
            MCP3_ARB_OWNED: begin
`ifdef MCP3_ARB32_WATCHDOG_EN
                // Release takes precedence; the watchdog only fires on an unreleased grant.
                if (!release_pulse && wd_cnt_q == MCP3_ARB_WD_W'(TIMEOUT_CYC)) begin
                    end_grant     = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
                if (end_grant) begin
                    state_d     = MCP3_ARB_IDLE;
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = '0;
                    ptr_d       = gnt_id_q + 5'd1;
                end
            end
            default: state_d = MCP3_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= MCP3_ARB_IDLE;
            ptr_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
`ifdef MCP3_ARB32_WATCHDOG_EN
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
`ifdef MCP3_ARB32_WATCHDOG_EN
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_id     = gnt_id_q;
    assign gnt_onehot = dec_onehot & {MCP3_ARB_NUM_REQ{gnt_valid_q}};
`ifdef MCP3_ARB32_WATCHDOG_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
